approx_umul_pipe: RTL and testbench
===================================

// Module: approx_umul_pipe
// PURPOSE
//  Parametrised, pipelined unsigned WIDTHxWIDTH approximate multiplier: next generation of the
//  fixed 8x8 row-truncated multipliers. The top WIDTH-LOW_ROWS rows of x are multiplied exactly.
//  The low LOW_ROWS rows are pruned below column KEEP_COL, and each pair of rows is merged with OR.
//  Per-transaction exact/approx mode select; valid/ready streaming with full backpressure.
//  Sits between operand FIFOs and accumulators in the approximate-datapath arrays.
// PARAMETERS
//  WIDTH     8      operand width, >=2
//  LOW_ROWS  6      number of approximated low rows of x, 0..WIDTH (0 = always exact)
//  KEEP_COL  WIDTH  lowest product column kept in approximated rows, 0..2*WIDTH-1
//  CNT_W     16     error-counter width (used only with AMUL_ERRSTAT_EN)
// PORTS
//  clk        in   1         clock, all logic rising-edge
//  rst_n      in   1         synchronous active-low reset
//  in_valid   in   1         operand beat valid
//  in_ready   out  1         block accepts beat this cycle
//  in_x       in   WIDTH     multiplier operand (rows)
//  in_y       in   WIDTH     multiplicand operand
//  in_exact   in   1         1 = exact product for this beat, 0 = approximate
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts result
//  out_z      out  2*WIDTH   product
//  out_exact  out  1         mode of the beat carried with out_z
//  err_clr    in   1         [AMUL_ERRSTAT_EN only] clear error counter
//  err_cnt    out  CNT_W     [AMUL_ERRSTAT_EN only] count of inexact results delivered
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous, active-low (rst_n sampled on clk edge).
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, out_z=0, out_exact=0, err_cnt=0. Reset
//    mid-operation drops all in-flight beats; in_ready=1 in the cycle after reset releases.
//  - Arithmetic (pp[i][j] = x[i]&y[j], weight i+j; H = high part):
//    H = (x[WIDTH-1:LOW_ROWS] * y) << LOW_ROWS, exact.
//    Exact mode: z = x*y (full 2*WIDTH result, no truncation).
//    Approx mode, rows paired (2k, 2k+1) for 2k+1 < LOW_ROWS, for each column c >= KEEP_COL:
//    a = pp[2k][c-2k], b = pp[2k+1][c-2k-1]; an index outside 0..WIDTH-1 gives 0.
//    Bit (a|b) is added at weight c.
//    If LOW_ROWS is odd, the last row LOW_ROWS-1 adds pp bits with weight >= KEEP_COL, exactly.
//    Columns < KEEP_COL of the low rows are dropped. z = H + sum of merged bits, mod 2^(2*WIDTH).
//    The approximate result never exceeds the exact result (OR <= sum, pruning only removes).
//  - Pipeline: 2 registered stages.
//    S1 latches the high-row product, the merged low vector and the mode.
//    S2 performs the final add into out_z.
//    Latency = 2 cycles from input handshake to out_valid when out_ready=1.
//  - Handshake: a beat transfers when valid&ready.
//    s2 advances when !s2_valid | out_ready; s1 advances when !s1_valid | s2 advances.
//    in_ready = !s1_valid | s2 advances, combinational from out_ready; there is no path from
//    in_valid to in_ready.
//    Full throughput of 1 beat/cycle when out_ready=1.
//    While out_valid=1 and out_ready=0, out_z and out_exact hold stable.
//    The pipeline stores at most 2 beats, and no beat is lost or duplicated.
//  - Simultaneous push and pop with both stages full: both succeed in the same cycle.
//  - Ordering: strictly FIFO. out_exact travels with its beat; mode may change every beat.
// CONFIGURATION
//  `AMUL_ERRSTAT_EN defined:
//    An exact product is also carried through the pipe.
//    On each out handshake with out_exact=0 and approx != exact, err_cnt increments, saturating
//    at 2^CNT_W-1.
//    err_clr sets err_cnt=0 next cycle and has priority over a simultaneous increment.
//  Not defined: err_clr/err_cnt ports absent; no exact shadow datapath.
// TESTING (WIDTH=8, LOW_ROWS=6, KEEP_COL=8 unless stated)
//  1. x=0xFF,y=0xFF: approx -> out_z=58944 (0xE640) at cycle +2; exact -> 65025 (0xFE01).
//  2. x=0x01,y=0xFF: approx -> 0; exact -> 255. x=0x40,y=0x03 either mode -> 192.
//  3. Back-to-back 16 beats, out_ready=1: one result/cycle, order and out_exact preserved.
//  4. out_ready=0 for 5 cycles with streaming input: in_ready drops after 2 accepted beats;
//     out_z stable; all beats delivered once on release.
//  5. rst_n=0 for 1 cycle with 2 beats in flight: out_valid=0 next cycle, no stale result.
//  6. AMUL_ERRSTAT_EN, CNT_W=2: 5 inexact approx beats -> err_cnt=3 (saturated); err_clr -> 0.
//     Random sweep: approx <= exact, and LOW_ROWS=0 always gives exact results.

Source files
------------

// File: rtl/approx_umul_pipe.sv
// approx_umul_pipe: pipelined unsigned WIDTH x WIDTH approximate multiplier.
// The high rows of x (bits WIDTH-1..LOW_ROWS) are multiplied exactly. The low rows are
// pruned below column KEEP_COL and merged pairwise with OR. Mode is selected per beat.
// Two registered stages with valid/ready handshaking and full backpressure.
// Optional feature macro: AMUL_ERRSTAT_EN adds an exact shadow product and a saturating
// counter of inexact approximate results (err_clr / err_cnt ports).
module approx_umul_pipe #(
    parameter int WIDTH    = 8,
    parameter int LOW_ROWS = 6,
    parameter int KEEP_COL = WIDTH,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_exact,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_z,
    output logic                 out_exact
`ifdef AMUL_ERRSTAT_EN
    ,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     err_cnt
`endif
);

    localparam int PW = 2 * WIDTH;

    // Rows of x that belong to the approximated (low) region.
    localparam logic [WIDTH-1:0] LO_MASK   = ~({WIDTH{1'b1}} << LOW_ROWS);
    // Product columns that survive pruning in the low rows.
    localparam logic [PW-1:0]    KEEP_MASK = {PW{1'b1}} << KEEP_COL;

    if (WIDTH < 2 || LOW_ROWS < 0 || LOW_ROWS > WIDTH ||
        KEEP_COL < 0 || KEEP_COL > 2 * WIDTH - 1 || CNT_W < 1) begin : g_bad_params
        $error("approx_umul_pipe: parameter out of range");
    end

    logic [PW-1:0]    w_y_ext;
    logic [WIDTH-1:0] w_x_lo;
    logic [PW-1:0]    w_hi;
    logic [PW-1:0]    w_lo_exact;
    logic [PW-1:0]    w_lo_apx;
    logic [PW-1:0]    w_lo_sel;
    logic [PW-1:0]    w_row_a;
    logic [PW-1:0]    w_row_b;
    logic [WIDTH-1:0] w_xs;
    logic             w_s2_adv;
    logic             w_s1_adv;

    logic             r_s1_valid;
    logic [PW-1:0]    r_s1_hi;
    logic [PW-1:0]    r_s1_lo;
    logic             r_s1_exact;
    logic             r_s2_valid;
    logic [PW-1:0]    r_out_z;
    logic             r_out_exact;

    assign w_y_ext    = {{WIDTH{1'b0}}, in_y};
    assign w_x_lo     = in_x & LO_MASK;
    // Masking the low rows out of x and multiplying equals (x_hi * y) << LOW_ROWS.
    assign w_hi       = {{WIDTH{1'b0}}, in_x & ~LO_MASK} * w_y_ext;
    assign w_lo_exact = {{WIDTH{1'b0}}, w_x_lo} * w_y_ext;

    // Approximate low-row vector: OR-merge each row pair, prune, then sum the pairs.
    always_comb begin
        w_lo_apx = '0;
        w_row_a  = '0;
        w_row_b  = '0;
        w_xs     = '0;
        for (int k = 0; 2 * k + 1 < LOW_ROWS; k++) begin
            w_xs     = w_x_lo >> (2 * k);
            w_row_a  = w_xs[0] ? (w_y_ext << (2 * k))     : '0;
            w_row_b  = w_xs[1] ? (w_y_ext << (2 * k + 1)) : '0;
            w_lo_apx = w_lo_apx + ((w_row_a | w_row_b) & KEEP_MASK);
        end
        // An unpaired last row is added exactly, still pruned below KEEP_COL.
        if (LOW_ROWS % 2 == 1) begin
            w_xs     = w_x_lo >> (LOW_ROWS - 1);
            w_row_a  = w_xs[0] ? (w_y_ext << (LOW_ROWS - 1)) : '0;
            w_lo_apx = w_lo_apx + (w_row_a & KEEP_MASK);
        end
    end

    assign w_lo_sel = in_exact ? w_lo_exact : w_lo_apx;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_z     = r_out_z;
    assign out_exact = r_out_exact;

`ifdef AMUL_ERRSTAT_EN
    logic [PW-1:0]    r_s1_lo_ex;
    logic [PW-1:0]    r_out_z_ex;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_out_fire;

    assign w_out_fire = r_s2_valid && out_ready;
    assign err_cnt    = r_err_cnt;

    // Exact shadow pipeline used only to detect inexact approximate results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_lo_ex <= '0;
            r_out_z_ex <= '0;
        end else begin
            if (w_s1_adv && in_valid) begin
                r_s1_lo_ex <= w_lo_exact;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_out_z_ex <= r_s1_hi + r_s1_lo_ex;
            end
        end
    end

    // Saturating count of delivered approximate results that differ from exact; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_fire && !r_out_exact && (r_out_z != r_out_z_ex) &&
                     (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
`endif

    // Stage 1: capture high product, selected low vector and mode when the stage advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hi    <= '0;
            r_s1_lo    <= '0;
            r_s1_exact <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_hi    <= w_hi;
                r_s1_lo    <= w_lo_sel;
                r_s1_exact <= in_exact;
            end
        end
    end

    // Stage 2: final add into the output register; holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_out_z     <= '0;
            r_out_exact <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_z     <= r_s1_hi + r_s1_lo;
                r_out_exact <= r_s1_exact;
            end
        end
    end

endmodule

// File: tb/tb_approx_umul_pipe.sv
// Testbench for approx_umul_pipe (WIDTH=8, LOW_ROWS=6, KEEP_COL=8), plus a LOW_ROWS=0
// instance sharing the same stimulus. Error-counter scenario runs when AMUL_ERRSTAT_EN is set.
module tb_approx_umul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_exact = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_x = 8'h00;
    logic [7:0]  in_y = 8'h00;
    logic        in_ready, out_valid, out_exact;
    logic [15:0] out_z;
    logic        in_ready0, out_valid0, out_exact0;
    logic [15:0] out_z0;
`ifdef AMUL_ERRSTAT_EN
    logic        err_clr = 1'b0;
    logic [1:0]  err_cnt, err_cnt0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] rx_z[$];
    logic [15:0] rx_z0[$];
    logic        rx_ex[$];

    localparam int NT = 10;
    logic [7:0]  tx [NT] = '{8'hFF, 8'hFF, 8'h01, 8'h01, 8'h40, 8'h40, 8'h3F, 8'h3F, 8'h03, 8'h03};
    logic [7:0]  ty [NT] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h81, 8'h81, 8'hC0, 8'hC0};
    logic        tex[NT] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] tz [NT] = '{16'd58944, 16'd65025, 16'd0, 16'd255, 16'd192, 16'd192,
                             16'd7936, 16'd8127, 16'd256, 16'd576};

    always #5 clk = ~clk;

    approx_umul_pipe #(.WIDTH(8), .LOW_ROWS(6), .KEEP_COL(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_exact(in_exact),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_exact(out_exact)
`ifdef AMUL_ERRSTAT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    approx_umul_pipe #(.WIDTH(8), .LOW_ROWS(0), .KEEP_COL(8), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_x(in_x), .in_y(in_y), .in_exact(in_exact),
        .out_valid(out_valid0), .out_ready(out_ready), .out_z(out_z0), .out_exact(out_exact0)
`ifdef AMUL_ERRSTAT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt0)
`endif
    );

    // Records handshakes seen before the edge, then advances one clock.
    task automatic tick(output logic acc);
        #1;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            rx_z.push_back(out_z);
            rx_z0.push_back(out_z0);
            rx_ex.push_back(out_exact);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_z.delete();
        rx_z0.delete();
        rx_ex.delete();
    endtask

    task automatic test_reset();
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick(acc);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (out_z !== 16'd0) begin n_errors++; $display("FAIL reset_out_z: got %0d expected 0", out_z); end
        n_checks++;
        if (out_exact !== 1'b0) begin n_errors++; $display("FAIL reset_out_exact: got %0b expected 0", out_exact); end
        rst_n = 1'b1;
        tick(acc);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        clear_rx();
    endtask

    task automatic test_latency();
        logic acc;
        out_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            in_valid = 1'b1; in_x = tx[i]; in_y = ty[i]; in_exact = tex[i];
            tick(acc);
            in_valid = 1'b0;
            n_checks++;
            if (acc !== 1'b1) begin n_errors++; $display("FAIL lat_accept[%0d]: got %0b expected 1", i, acc); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lat_early[%0d]: got %0b expected 0", i, out_valid); end
            tick(acc);
            n_checks++;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL lat_valid[%0d]: got %0b expected 1", i, out_valid); end
            n_checks++;
            if (out_z !== tz[i]) begin n_errors++; $display("FAIL lat_z[%0d]: got %0d expected %0d", i, out_z, tz[i]); end
            n_checks++;
            if (out_exact !== tex[i]) begin n_errors++; $display("FAIL lat_exact[%0d]: got %0b expected %0b", i, out_exact, tex[i]); end
            tick(acc);
        end
        clear_rx();
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   b;
        clear_rx();
        out_ready = 1'b1;
        b = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1; in_x = tx[b % NT]; in_y = ty[b % NT]; in_exact = tex[b % NT];
            tick(acc);
            n_checks++;
            if (acc !== 1'b1) begin n_errors++; $display("FAIL b2b_accept[%0d]: got %0b expected 1", c, acc); end
            if (acc) b++;
        end
        in_valid = 1'b0;
        repeat (2) tick(acc);
        n_checks++;
        if (rx_z.size() != 16) begin n_errors++; $display("FAIL b2b_count: got %0d expected 16", rx_z.size()); end
        for (int i = 0; i < 16 && i < rx_z.size(); i++) begin
            n_checks++;
            if (rx_z[i] !== tz[i % NT] || rx_ex[i] !== tex[i % NT]) begin
                n_errors++;
                $display("FAIL b2b_beat[%0d]: got %0d/%0b expected %0d/%0b", i, rx_z[i], rx_ex[i], tz[i % NT], tex[i % NT]);
            end
        end
        repeat (2) tick(acc);
        clear_rx();
    endtask

    task automatic test_stall();
        logic acc;
        int   b;
        clear_rx();
        out_ready = 1'b0;
        b = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_x = tx[b]; in_y = ty[b]; in_exact = tex[b];
            tick(acc);
            if (acc) b++;
            if (c >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_z !== tz[0] || out_exact !== tex[0]) begin
                    n_errors++;
                    $display("FAIL stall_hold[%0d]: got %0b/%0d/%0b expected 1/%0d/%0b", c, out_valid, out_z, out_exact, tz[0], tex[0]);
                end
            end
        end
        n_checks++;
        if (b != 2) begin n_errors++; $display("FAIL stall_accepted: got %0d expected 2", b); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && b < 6; c++) begin
            in_valid = 1'b1; in_x = tx[b]; in_y = ty[b]; in_exact = tex[b];
            tick(acc);
            if (acc) b++;
        end
        in_valid = 1'b0;
        repeat (4) tick(acc);
        n_checks++;
        if (rx_z.size() != 6) begin n_errors++; $display("FAIL stall_count: got %0d expected 6", rx_z.size()); end
        for (int i = 0; i < 6 && i < rx_z.size(); i++) begin
            n_checks++;
            if (rx_z[i] !== tz[i] || rx_ex[i] !== tex[i]) begin
                n_errors++;
                $display("FAIL stall_beat[%0d]: got %0d/%0b expected %0d/%0b", i, rx_z[i], rx_ex[i], tz[i], tex[i]);
            end
        end
        clear_rx();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        clear_rx();
        out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; in_x = tx[i]; in_y = ty[i]; in_exact = tex[i];
            tick(acc);
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_inflight: got %0b expected 1", out_valid); end
        rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_in_ready: got %0b expected 1", in_ready); end
        out_ready = 1'b1;
        repeat (4) tick(acc);
        n_checks++;
        if (rx_z.size() != 0) begin n_errors++; $display("FAIL mid_stale: got %0d results expected 0", rx_z.size()); end
        in_valid = 1'b1; in_x = tx[8]; in_y = ty[8]; in_exact = tex[8];
        tick(acc);
        in_valid = 1'b0;
        repeat (3) tick(acc);
        n_checks++;
        if (rx_z.size() != 1 || rx_z[0] !== tz[8]) begin
            n_errors++;
            $display("FAIL mid_recover: got %0d results expected 1 of %0d", rx_z.size(), tz[8]);
        end
        clear_rx();
    endtask

    task automatic test_random();
        logic        acc;
        logic [15:0] q_prod[$];
        logic        q_mode[$];
        int          sent;
        clear_rx();
        sent = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = (sent < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_x      = 8'($urandom);
            in_y      = 8'($urandom);
            in_exact  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                q_prod.push_back({8'h00, in_x} * {8'h00, in_y});
                q_mode.push_back(in_exact);
                sent++;
            end
            n_checks++;
            if (out_valid0 !== out_valid || in_ready0 !== in_ready || out_exact0 !== out_exact) begin
                n_errors++;
                $display("FAIL rnd_flow[%0d]: got %0b%0b%0b expected %0b%0b%0b", c, out_valid0, in_ready0, out_exact0, out_valid, in_ready, out_exact);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick(acc);
        n_checks++;
        if (rx_z.size() != q_prod.size()) begin n_errors++; $display("FAIL rnd_count: got %0d expected %0d", rx_z.size(), q_prod.size()); end
        for (int i = 0; i < rx_z.size() && i < q_prod.size(); i++) begin
            n_checks++;
            if (rx_ex[i] !== q_mode[i] || rx_z[i] > q_prod[i] || (q_mode[i] && rx_z[i] !== q_prod[i])) begin
                n_errors++;
                $display("FAIL rnd_beat[%0d]: got %0d/%0b expected %0d/%0b", i, rx_z[i], rx_ex[i], q_prod[i], q_mode[i]);
            end
            n_checks++;
            if (rx_z0[i] !== q_prod[i]) begin
                n_errors++;
                $display("FAIL rnd_exact0[%0d]: got %0d expected %0d", i, rx_z0[i], q_prod[i]);
            end
        end
        clear_rx();
    endtask

`ifdef AMUL_ERRSTAT_EN
    task automatic test_errstat();
        logic acc;
        int   seq_a[4] = '{0, 0, 1, 4};
        out_ready = 1'b1;
        err_clr = 1'b1; tick(acc); err_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = tx[seq_a[i]]; in_y = ty[seq_a[i]]; in_exact = tex[seq_a[i]];
            tick(acc);
        end
        in_valid = 1'b0;
        repeat (3) tick(acc);
        n_checks++;
        if (err_cnt !== 2'd2) begin n_errors++; $display("FAIL err_two: got %0d expected 2", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_x = tx[0]; in_y = ty[0]; in_exact = tex[0];
            tick(acc);
        end
        in_valid = 1'b0;
        repeat (3) tick(acc);
        n_checks++;
        if (err_cnt !== 2'd3) begin n_errors++; $display("FAIL err_sat: got %0d expected 3", err_cnt); end
        n_checks++;
        if (err_cnt0 !== 2'd0) begin n_errors++; $display("FAIL err_exact0: got %0d expected 0", err_cnt0); end
        err_clr = 1'b1; tick(acc); err_clr = 1'b0;
        n_checks++;
        if (err_cnt !== 2'd0) begin n_errors++; $display("FAIL err_clr: got %0d expected 0", err_cnt); end
        in_valid = 1'b1; in_x = tx[0]; in_y = ty[0]; in_exact = tex[0];
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        err_clr = 1'b1; tick(acc); err_clr = 1'b0;
        n_checks++;
        if (err_cnt !== 2'd0) begin n_errors++; $display("FAIL err_clr_prio: got %0d expected 0", err_cnt); end
        clear_rx();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
`ifdef AMUL_ERRSTAT_EN
        test_errstat();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
